// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage and IF/ID pipeline register of a 5-stage MIPS
//   pipeline. Holds the fetch PC, addresses instruction memory combinationally,
//   and latches the fetched word (with its PC+4) into the register read by ID.
//   Redirects (jr / j / taken branch) are resolved in ID and steer the PC; the
//   instruction already fetched on the wrong path is squashed to a bubble
//   (there is no branch delay slot).
//
// Ports
//   clock, reset      single rising-edge clock, asynchronous active-high reset
//   stall             ID load-use stall: freezes PC, IF/ID register, fetchCount
//   isBranch          taken conditional branch in ID
//   isJump            j/jal in ID
//   isJumpRegister    jr in ID
//   idImmediate       sign-extended branch offset (in words) from ID
//   idJumpIndex       26-bit instr_index of the jump in ID
//   registerA         forwarded rs value in ID (jr target)
//   imemAddress       instruction memory address (always equal to pc)
//   imemData          instruction memory read data, same cycle
//   imemReady         imemData is valid this cycle
//   pc                current fetch PC
//   ifInstruction     word in IF: imemData when ready, otherwise the NOP word
//   idInstruction     IF/ID register: instruction presented to ID
//   idPcPlus4         IF/ID register: PC+4 of idInstruction
//   idValid           idInstruction is a real fetched word (0 = bubble)
//   jrMisaligned      sticky flag: a jr to a target with nonzero [1:0] was taken
//   fetchCount        number of instructions delivered to ID (wraps)
//
// Handshake: the memory side has a single qualifier, imemReady. A word is
//   accepted on a rising edge exactly when imemReady=1 and neither stall nor
//   a redirect is active on that edge; only then does pc advance and the word
//   enter the IF/ID register with idValid=1. Otherwise the memory address
//   either holds (retry next cycle) or moves to the redirect target.
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        isBranch,
  input  logic        isJump,
  input  logic        isJumpRegister,
  input  logic [31:0] idImmediate,
  input  logic [25:0] idJumpIndex,
  input  logic [31:0] registerA,
  output logic [31:0] imemAddress,
  input  logic [31:0] imemData,
  input  logic        imemReady,
  output logic [31:0] pc,
  output logic [31:0] ifInstruction,
  output logic [31:0] idInstruction,
  output logic [31:0] idPcPlus4,
  output logic        idValid,
  output logic        jrMisaligned,
  output logic [31:0] fetchCount
);

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] jr_target;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] redirect_target;
  logic        jr_bad_align;

  assign pc_plus4 = pc + 32'd4;   // modulo 2^32, FFFF_FFFC wraps to 0
  assign redirect = isJumpRegister | isJump | isBranch;

  // Targets are all formed relative to the instruction sitting in ID, hence
  // idPcPlus4 rather than the fetch pc.
  assign jr_target     = {registerA[31:2], 2'b00};
  assign jump_target   = {idPcPlus4[31:28], idJumpIndex, 2'b00};
  assign branch_target = idPcPlus4 + {idImmediate[29:0], 2'b00};

  // jr has the highest priority, then j, then the taken branch.
  always_comb begin
    redirect_target = branch_target;
    if (isJumpRegister) begin
      redirect_target = jr_target;
    end else if (isJump) begin
      redirect_target = jump_target;
    end
  end

  assign jr_bad_align = isJumpRegister && (registerA[1:0] != 2'b00);

  assign imemAddress   = pc;
  assign ifInstruction = imemReady ? imemData : NOP_INSTRUCTION;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc            <= RESET_PC;
      idInstruction <= NOP_INSTRUCTION;
      idPcPlus4     <= RESET_PC;
      idValid       <= 1'b0;
      jrMisaligned  <= 1'b0;
      fetchCount    <= 32'd0;
    end else if (stall) begin
      // Everything holds; a redirect seen during a stall is re-presented by
      // ID once the stall clears, so it is deliberately ignored here.
    end else if (redirect) begin
      // The word fetched this cycle is on the wrong path: drop it, leave
      // idPcPlus4 alone, and restart fetch at the target.
      pc            <= redirect_target;
      idInstruction <= NOP_INSTRUCTION;
      idValid       <= 1'b0;
      if (jr_bad_align) begin
        jrMisaligned <= 1'b1;
      end
    end else if (!imemReady) begin
      // Memory not ready: retry the same address and feed ID a bubble.
      idInstruction <= NOP_INSTRUCTION;
      idValid       <= 1'b0;
    end else begin
      pc            <= pc_plus4;
      idInstruction <= imemData;
      idPcPlus4     <= pc_plus4;
      idValid       <= 1'b1;
      fetchCount    <= fetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
//   Bench for if_stage. A driver applies directed and random stimulus on the
//   falling edge and advances a reference model of the fetch stage; the
//   expected post-edge state is pushed into exp_q. A monitor pops one entry
//   after every rising edge and compares it with the DUT outputs. Instruction
//   memory is a pure function of the address, so the expected fetched word is
//   known from the model PC alone.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam int          W        = 130;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        isBranch;
  logic        isJump;
  logic        isJumpRegister;
  logic [31:0] idImmediate;
  logic [25:0] idJumpIndex;
  logic [31:0] registerA;
  logic [31:0] imemAddress;
  logic [31:0] imemData;
  logic        imemReady;
  logic [31:0] pc;
  logic [31:0] ifInstruction;
  logic [31:0] idInstruction;
  logic [31:0] idPcPlus4;
  logic        idValid;
  logic        jrMisaligned;
  logic [31:0] fetchCount;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_idi;
  logic [31:0] m_idpc4;
  logic [31:0] m_fc;
  logic        m_idv;
  logic        m_jrm;

  if_stage #(
    .RESET_PC        (RESET_PC),
    .NOP_INSTRUCTION (NOP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .isBranch       (isBranch),
    .isJump         (isJump),
    .isJumpRegister (isJumpRegister),
    .idImmediate    (idImmediate),
    .idJumpIndex    (idJumpIndex),
    .registerA      (registerA),
    .imemAddress    (imemAddress),
    .imemData       (imemData),
    .imemReady      (imemReady),
    .pc             (pc),
    .ifInstruction  (ifInstruction),
    .idInstruction  (idInstruction),
    .idPcPlus4      (idPcPlus4),
    .idValid        (idValid),
    .jrMisaligned   (jrMisaligned),
    .fetchCount     (fetchCount)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- instruction memory ----------------
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imemData = imemReady ? word_at(imemAddress) : 32'hDEAD_BEEF;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_model();
    return {m_pc, m_idi, m_idpc4, m_fc, m_idv, m_jrm};
  endfunction

  // monitor: one expected entry per rising edge outside reset
  always @(posedge clock) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc",            pc,                 e[129:98]);
      check("id_instruction", idInstruction,     e[97:66]);
      check("id_pc_plus4",   idPcPlus4,          e[65:34]);
      check("fetch_count",   fetchCount,         e[33:2]);
      check("id_valid",      {31'd0, idValid},      {31'd0, e[1]});
      check("jr_misaligned", {31'd0, jrMisaligned}, {31'd0, e[0]});
    end
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pc    = RESET_PC;
    m_idi   = NOP;
    m_idpc4 = RESET_PC;
    m_fc    = 0;
    m_idv   = 1'b0;
    m_jrm   = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic br, input logic j, input logic jr,
                            input logic [31:0] imm, input logic [25:0] idx,
                            input logic [31:0] ra, input logic rdy);
    logic [31:0] target;
    if (s) begin
      return;
    end
    if (jr || j || br) begin
      if (jr) begin
        target = ra & ~32'd3;
        if (ra % 4 != 0) m_jrm = 1'b1;
      end else if (j) begin
        target = (m_idpc4 & 32'hF000_0000) | ({6'd0, idx} * 4);
      end else begin
        target = m_idpc4 + imm * 4;
      end
      m_pc  = target;
      m_idi = NOP;
      m_idv = 1'b0;
    end else if (!rdy) begin
      m_idi = NOP;
      m_idv = 1'b0;
    end else begin
      m_idi   = word_at(m_pc);
      m_idpc4 = m_pc + 4;
      m_pc    = m_pc + 4;
      m_idv   = 1'b1;
      m_fc    = m_fc + 1;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives inputs for the next rising edge and
  // returns at the following falling edge.
  task automatic step(input logic s, input logic br, input logic j, input logic jr,
                      input logic [31:0] imm, input logic [25:0] idx,
                      input logic [31:0] ra, input logic rdy);
    stall          = s;
    isBranch       = br;
    isJump         = j;
    isJumpRegister = jr;
    idImmediate    = imm;
    idJumpIndex    = idx;
    registerA      = ra;
    imemReady      = rdy;
    #1;
    check("imem_address",   imemAddress,   m_pc);
    check("if_instruction", ifInstruction, rdy ? word_at(m_pc) : NOP);
    model_edge(s, br, j, jr, imm, idx, ra, rdy);
    exp_q.push_back(pack_model());
    @(negedge clock);
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic check_reset_values();
    check("rst_pc",            pc,                     RESET_PC);
    check("rst_id_instruction", idInstruction,         NOP);
    check("rst_id_pc_plus4",   idPcPlus4,              RESET_PC);
    check("rst_id_valid",      {31'd0, idValid},       32'd0);
    check("rst_jr_misaligned", {31'd0, jrMisaligned},  32'd0);
    check("rst_fetch_count",   fetchCount,             32'd0);
  endtask

  // Asserts reset between edges and checks it acts without a clock edge.
  task automatic mid_reset();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        s, br, j, jr, rdy;
    logic [31:0] imm, ra;
    logic [25:0] idx;
    int          kind;

    reset = 1'b1;
    stall = 0; isBranch = 0; isJump = 0; isJumpRegister = 0;
    idImmediate = 0; idJumpIndex = 0; registerA = 0; imemReady = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_reset_values();
    reset = 1'b0;

    // sequential fetch: pc 0 -> 4 -> 8, i0/i1 reach ID
    fetch(2);
    // two-cycle stall at pc=8, redirect offered during the stall is ignored
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 26'h3FF, 0, 1);
    // resume at 8, reach idPcPlus4=0x14
    fetch(3);
    // taken branch: 0x14 + (-2)*4 = 0x0C
    step(0, 1, 0, 0, 32'hFFFF_FFFE, 0, 0, 1);
    // jr to 0x9000_0000, fetch, then j index 0x40 -> 0x9000_0100
    step(0, 0, 0, 1, 0, 0, 32'h9000_0000, 1);
    fetch(1);
    step(0, 0, 1, 0, 0, 26'h000_0040, 0, 1);
    fetch(1);
    // jr and j together: jr target wins
    step(0, 0, 1, 1, 0, 26'h12_3456, 32'h0000_0200, 1);
    // misaligned jr sets the sticky flag
    step(0, 0, 0, 1, 0, 0, 32'h0000_0103, 1);
    fetch(2);
    // stall + jump together: pc holds
    step(1, 0, 1, 0, 0, 26'h000_0010, 0, 1);
    // memory not ready for three cycles
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    fetch(1);
    // redirect while memory is not ready
    step(0, 1, 0, 0, 32'd8, 0, 0, 0);
    // wrap from FFFF_FFFC to 0
    step(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 1);
    fetch(2);
    // reset while waiting on memory
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    mid_reset();
    fetch(2);

    // random phase
    for (int n = 0; n < 400; n++) begin
      if (n == 200) mid_reset();
      s    = ($urandom_range(0, 99) < 15);
      rdy  = ($urandom_range(0, 99) < 80);
      kind = $urandom_range(0, 99);
      br   = (kind < 8);
      j    = (kind >= 8 && kind < 13) || (kind >= 95);
      jr   = (kind >= 13 && kind < 18) || (kind >= 97);
      imm  = $urandom_range(0, 63);
      imm  = imm - 32'd32;
      idx  = 26'($urandom);
      ra   = $urandom & 32'hF000_0FFF;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      step(s, br, j, jr, imm, idx, ra, rdy);
    end

    @(posedge clock);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
